lc3_execute_stage: RTL and testbench

//  LC3 execute stage; consumes the decode-stage bundle (IR, npc, E_control, W_control, Mem_control).

---
 rtl/lc3_execute_stage.sv | 127 ++++++++++++
 tb/tb_lc3_execute_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lc3_execute_stage.sv
// LC3 pipeline execute stage: operand bypass, ALU, address adder and branch mask,
// with all results registered one cycle toward the writeback/memory stages.
module lc3_execute_stage #(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_execute,
  input  logic [15:0] IR,
  input  logic [15:0] npc_in,
  input  logic [5:0]  E_control,
  input  logic [1:0]  W_control_in,
  input  logic        Mem_control_in,
  input  logic [15:0] VSR1,
  input  logic [15:0] VSR2,
  input  logic        bypass_alu_1,
  input  logic        bypass_alu_2,
  input  logic        bypass_mem_1,
  input  logic        bypass_mem_2,
  input  logic [15:0] Mem_Bypass_Val,
  output logic [2:0]  sr1,
  output logic [2:0]  sr2,
  output logic [15:0] aluout,
  output logic [15:0] pcout,
  output logic [1:0]  W_control_out,
  output logic        Mem_control_out,
  output logic [15:0] M_data,
  output logic [2:0]  dr,
  output logic [2:0]  NZP,
  output logic [15:0] IR_exec
);

  logic [3:0]  opcode;
  logic [1:0]  alu_op;
  logic [1:0]  pcsel1;
  logic        pcsel2;
  logic        op2sel;
  logic [15:0] op1;
  logic [15:0] op2;
  logic [15:0] alu_b;
  logic [15:0] alu_res;
  logic [15:0] addr_a;
  logic [15:0] addr_b;
  logic [15:0] pc_sum;
  logic [15:0] aluout_next;
  logic [2:0]  nzp_next;

  assign opcode = IR[15:12];
  assign alu_op = E_control[5:4];
  assign pcsel1 = E_control[3:2];
  assign pcsel2 = E_control[1];
  assign op2sel = E_control[0];

  // Stores read their source register through the sr2 port.
  assign sr1 = IR[8:6];
  assign sr2 = (opcode == 4'b0011 || opcode == 4'b0111 || opcode == 4'b1011) ? IR[11:9] : IR[2:0];

  // aluout here is the value still held from the previous instruction.
  always_comb begin
    op1 = VSR1;
    op2 = VSR2;
    if (BYPASS_EN) begin
      if (bypass_alu_1)      op1 = aluout;
      else if (bypass_mem_1) op1 = Mem_Bypass_Val;
      if (bypass_alu_2)      op2 = aluout;
      else if (bypass_mem_2) op2 = Mem_Bypass_Val;
    end
  end

  assign alu_b = op2sel ? op2 : {{11{IR[4]}}, IR[4:0]};

  always_comb begin
    case (alu_op)
      2'b01:   alu_res = op1 & alu_b;
      2'b10:   alu_res = ~op1;
      default: alu_res = op1 + alu_b;
    endcase
  end

  assign addr_a = pcsel2 ? npc_in : op1;

  always_comb begin
    case (pcsel1)
      2'b00:   addr_b = {{5{IR[10]}}, IR[10:0]};
      2'b01:   addr_b = {{7{IR[8]}}, IR[8:0]};
      2'b10:   addr_b = {{10{IR[5]}}, IR[5:0]};
      default: addr_b = 16'h0000;
    endcase
  end

  assign pc_sum = addr_a + addr_b;

  always_comb begin
    aluout_next = pc_sum;
    if (opcode == 4'b0001 || opcode == 4'b0101 || opcode == 4'b1001)
      aluout_next = alu_res;
  end

  always_comb begin
    nzp_next = 3'b000;
    if (opcode == 4'b0000)      nzp_next = IR[11:9];
    else if (opcode == 4'b1100) nzp_next = 3'b111;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      aluout          <= 16'h0000;
      pcout           <= 16'h0000;
      W_control_out   <= 2'b00;
      Mem_control_out <= 1'b0;
      M_data          <= 16'h0000;
      dr              <= 3'b000;
      NZP             <= 3'b000;
      IR_exec         <= 16'h0000;
    end else if (enable_execute) begin
      aluout          <= aluout_next;
      pcout           <= pc_sum;
      W_control_out   <= W_control_in;
      Mem_control_out <= Mem_control_in;
      M_data          <= op2;
      dr              <= IR[11:9];
      NZP             <= nzp_next;
      IR_exec         <= IR;
    end
  end

endmodule

// File: tb/tb_lc3_execute_stage.sv
// Directed-vector bench for lc3_execute_stage; a second instance runs with bypass disabled.
module tb_lc3_execute_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable_execute = 1'b0;
  logic [15:0] IR = 16'h0000;
  logic [15:0] npc_in = 16'h0000;
  logic [5:0]  E_control = 6'b0;
  logic [1:0]  W_control_in = 2'b00;
  logic        Mem_control_in = 1'b0;
  logic [15:0] VSR1 = 16'h0000;
  logic [15:0] VSR2 = 16'h0000;
  logic        bypass_alu_1 = 1'b0;
  logic        bypass_alu_2 = 1'b0;
  logic        bypass_mem_1 = 1'b0;
  logic        bypass_mem_2 = 1'b0;
  logic [15:0] Mem_Bypass_Val = 16'h0000;

  logic [2:0]  sr1, sr2, dr, NZP;
  logic [15:0] aluout, pcout, M_data, IR_exec;
  logic [1:0]  W_control_out;
  logic        Mem_control_out;

  logic [2:0]  nb_sr1, nb_sr2, nb_dr, nb_NZP;
  logic [15:0] nb_aluout, nb_pcout, nb_M_data, nb_IR_exec;
  logic [1:0]  nb_W_control_out;
  logic        nb_Mem_control_out;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  lc3_execute_stage #(.BYPASS_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .enable_execute(enable_execute), .IR(IR), .npc_in(npc_in),
    .E_control(E_control), .W_control_in(W_control_in), .Mem_control_in(Mem_control_in),
    .VSR1(VSR1), .VSR2(VSR2), .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2),
    .bypass_mem_1(bypass_mem_1), .bypass_mem_2(bypass_mem_2), .Mem_Bypass_Val(Mem_Bypass_Val),
    .sr1(sr1), .sr2(sr2), .aluout(aluout), .pcout(pcout), .W_control_out(W_control_out),
    .Mem_control_out(Mem_control_out), .M_data(M_data), .dr(dr), .NZP(NZP), .IR_exec(IR_exec)
  );

  lc3_execute_stage #(.BYPASS_EN(1'b0)) dut_nb (
    .clock(clock), .reset(reset), .enable_execute(enable_execute), .IR(IR), .npc_in(npc_in),
    .E_control(E_control), .W_control_in(W_control_in), .Mem_control_in(Mem_control_in),
    .VSR1(VSR1), .VSR2(VSR2), .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2),
    .bypass_mem_1(bypass_mem_1), .bypass_mem_2(bypass_mem_2), .Mem_Bypass_Val(Mem_Bypass_Val),
    .sr1(nb_sr1), .sr2(nb_sr2), .aluout(nb_aluout), .pcout(nb_pcout),
    .W_control_out(nb_W_control_out), .Mem_control_out(nb_Mem_control_out), .M_data(nb_M_data),
    .dr(nb_dr), .NZP(nb_NZP), .IR_exec(nb_IR_exec)
  );

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [15:0] ir, input logic [5:0] ec,
                       input logic [15:0] v1, input logic [15:0] v2);
    IR = ir;
    E_control = ec;
    VSR1 = v1;
    VSR2 = v2;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, ".aluout"}, aluout, 16'h0);
    check_val({tag, ".pcout"}, pcout, 16'h0);
    check_val({tag, ".M_data"}, M_data, 16'h0);
    check_val({tag, ".IR_exec"}, IR_exec, 16'h0);
    check_val({tag, ".misc"}, {5'd0, W_control_out, Mem_control_out, 2'b0, dr, NZP},
              16'h0);
  endtask

  logic [15:0] h_alu, h_pc, h_md, h_ir;
  logic [2:0]  h_nzp, h_dr;

  initial begin
    // Reset held, then released with enable low
    #12;
    check_all_zero("reset");
    reset = 1'b0;
    drive(16'h1283, 6'b000001, 16'hFFFF, 16'h0002);
    tick();
    tick();
    check_all_zero("idle");

    // ADD register form
    enable_execute = 1'b1;
    W_control_in = 2'b10;
    Mem_control_in = 1'b1;
    #1;
    check_val("add_reg.sr1", {13'd0, sr1}, 16'd2);
    check_val("add_reg.sr2", {13'd0, sr2}, 16'd3);
    tick();
    check_val("add_reg.aluout", aluout, 16'h0001);
    check_val("add_reg.dr", {13'd0, dr}, 16'd1);
    check_val("add_reg.pcout", pcout, 16'h0282);
    check_val("add_reg.M_data", M_data, 16'h0002);
    check_val("add_reg.IR_exec", IR_exec, 16'h1283);
    check_val("add_reg.wmem", {13'd0, W_control_out, Mem_control_out}, 16'h0005);
    check_val("add_reg.NZP", {13'd0, NZP}, 16'h0);
    W_control_in = 2'b00;
    Mem_control_in = 1'b0;

    // ADD immediate -16, AND, NOT
    drive(16'h1230, 6'b000000, 16'h0010, 16'h9999);
    tick();
    check_val("add_imm.aluout", aluout, 16'h0000);
    drive(16'h5042, 6'b010001, 16'hF0F0, 16'h0FF0);
    tick();
    check_val("and.aluout", aluout, 16'h00F0);
    drive(16'h903F, 6'b100000, 16'h00FF, 16'h1111);
    tick();
    check_val("not.aluout", aluout, 16'hFF00);

    // BR with npc-relative target, then JMP through register
    npc_in = 16'h3001;
    drive(16'h0A05, 6'b000110, 16'h7777, 16'h0000);
    tick();
    check_val("br.pcout", pcout, 16'h3006);
    check_val("br.aluout", aluout, 16'h3006);
    check_val("br.NZP", {13'd0, NZP}, 16'h0005);
    drive(16'hC1C0, 6'b001100, 16'h4000, 16'h0000);
    #1;
    check_val("jmp.sr1", {13'd0, sr1}, 16'd7);
    tick();
    check_val("jmp.pcout", pcout, 16'h4000);
    check_val("jmp.NZP", {13'd0, NZP}, 16'h0007);

    // Forwarding: load 1234 into aluout, then bypass with both selects high
    drive(16'h1020, 6'b000000, 16'h1234, 16'h0000);
    tick();
    check_val("pre_byp.aluout", aluout, 16'h1234);
    drive(16'h1021, 6'b000000, 16'h0007, 16'h0000);
    Mem_Bypass_Val = 16'h5555;
    bypass_alu_1 = 1'b1;
    bypass_mem_1 = 1'b1;
    tick();
    check_val("byp_both.aluout", aluout, 16'h1235);
    check_val("byp_off.aluout", nb_aluout, 16'h0008);
    bypass_alu_1 = 1'b0;
    tick();
    check_val("byp_mem.aluout", aluout, 16'h5556);
    check_val("byp_mem_off.aluout", nb_aluout, 16'h0008);
    bypass_mem_1 = 1'b0;
    drive(16'h1001, 6'b000001, 16'h0001, 16'h0010);
    bypass_alu_2 = 1'b1;
    tick();
    check_val("byp_op2.aluout", aluout, 16'h5557);
    check_val("byp_op2.M_data", M_data, 16'h5556);
    check_val("byp_op2_off.aluout", nb_aluout, 16'h0011);
    check_val("byp_op2_off.M_data", nb_M_data, 16'h0010);
    bypass_alu_2 = 1'b0;
    drive(16'h1001, 6'b000001, 16'h0001, 16'h0010);
    Mem_Bypass_Val = 16'h0100;
    bypass_mem_2 = 1'b1;
    tick();
    check_val("byp_mem2.aluout", aluout, 16'h0101);
    bypass_mem_2 = 1'b0;

    // Store: source register comes out on sr2 and lands in M_data
    drive(16'h3A02, 6'b000000, 16'h1000, 16'hABCD);
    #1;
    check_val("st.sr2", {13'd0, sr2}, 16'd5);
    tick();
    check_val("st.M_data", M_data, 16'hABCD);
    check_val("st.pcout", pcout, 16'h1202);
    check_val("st.aluout", aluout, 16'h1202);

    // Hold: inputs keep changing while enable is low
    h_alu = aluout; h_pc = pcout; h_md = M_data; h_ir = IR_exec; h_nzp = NZP; h_dr = dr;
    enable_execute = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(16'h0E00 + 16'(i), 6'b000110, 16'h2222 + 16'(i), 16'h3333 + 16'(i));
      npc_in = 16'h5000 + 16'(i);
      tick();
      check_val($sformatf("hold%0d.aluout", i), aluout, h_alu);
      check_val($sformatf("hold%0d.pcout", i), pcout, h_pc);
      check_val($sformatf("hold%0d.M_data", i), M_data, h_md);
      check_val($sformatf("hold%0d.IR_exec", i), IR_exec, h_ir);
      check_val($sformatf("hold%0d.nzp_dr", i), {10'd0, h_dr, NZP}, {10'd0, dr, h_nzp});
    end

    // Asynchronous reset mid-cycle with enable high, held across an edge
    enable_execute = 1'b1;
    drive(16'h1283, 6'b000001, 16'hFFFF, 16'h0002);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    check_val("async_rst.sr1", {13'd0, sr1}, 16'd2);
    tick();
    check_all_zero("rst_held");
    enable_execute = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    check_all_zero("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
